// File: rtl/exec_pkg.sv
// exec_pkg: opcode encodings, sequencer states and opcode helper functions.
package exec_pkg;
    localparam logic [1:0] CLS_INT = 2'b00;
    localparam logic [1:0] CLS_FIX = 2'b01;
    localparam logic [1:0] CLS_VEC = 2'b10;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int op_latency(logic [4:0] opcode, int mul_lat);
        return (opcode[2:0] == OP_MUL) ? mul_lat : 1;
    endfunction

    function automatic logic op_supported(logic [4:0] opcode);
        return (opcode[4:3] != 2'b11) && (opcode[2:0] <= OP_MUL);
    endfunction
endpackage

// File: rtl/exec_sequencer.sv
// exec_sequencer: issues one op lane-by-lane to a shared scalar Execution unit and returns the packed result.
module exec_sequencer
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LANES  = 4,
    parameter int MUL_LAT    = 3,
    parameter int TAG_W      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [4:0]                      in_opcode,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_a,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0]                in_tag,
    output logic [DATA_WIDTH-1:0]           alu_a,
    output logic [DATA_WIDTH-1:0]           alu_b,
    output logic [4:0]                      alu_opcode,
    input  logic [DATA_WIDTH-1:0]           alu_result,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
    output logic [TAG_W-1:0]                out_tag,
    output logic                            out_err,
    output logic                            busy
);
    localparam int W      = NUM_LANES * DATA_WIDTH;
    localparam int CNT_W  = $clog2(MUL_LAT + 1);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    state_t              state_q, state_d;
    logic [4:0]          op_q, op_d;
    logic [W-1:0]        a_q, a_d, b_q, b_d, buf_q, buf_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [LANE_W-1:0]   lane_q, lane_d, last;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d, run;

    assign run        = (state_q == RUN);
    assign last       = (op_q[4:3] == CLS_VEC) ? LANE_W'(NUM_LANES - 1) : '0;
    assign alu_a      = run ? a_q[lane_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign alu_b      = run ? b_q[lane_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign alu_opcode = run ? op_q : '0;
    assign in_ready   = (state_q == IDLE);
    assign busy       = !in_ready;
    assign out_valid  = (state_q == DONE);
    assign out_data   = buf_q;
    assign out_tag    = tag_q;
    assign out_err    = err_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (in_valid && !flush) begin
                op_d    = in_opcode;
                a_d     = in_a;
                b_d     = in_b;
                tag_d   = in_tag;
                buf_d   = '0;
                lane_d  = '0;
                cnt_d   = CNT_W'(op_latency(in_opcode, MUL_LAT) - 1);
                err_d   = !op_supported(in_opcode);
                state_d = op_supported(in_opcode) ? RUN : DONE;
            end
            RUN: if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                buf_d[lane_q*DATA_WIDTH +: DATA_WIDTH] = alu_result;
                if (lane_q == last) begin
                    state_d = DONE;
                end else begin
                    lane_d = lane_q + 1'b1;
                    cnt_d  = CNT_W'(op_latency(op_q, MUL_LAT) - 1);
                end
            end
            DONE: if (out_ready) begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // flush drops any in-flight or finished result without a handshake
        if (flush) begin
            state_d = IDLE;
            err_d   = 1'b0;
            buf_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed checks of exec_sequencer with a behavioural Execution unit.
module tb_exec_sequencer;
    localparam int DW = 16;
    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic          in_ready, out_valid, out_err, busy;
    logic [4:0]    in_opcode, alu_opcode;
    logic [63:0]   in_a, in_b, out_data;
    logic [3:0]    in_tag, out_tag;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    int            errors = 0;
    int            checks = 0;
    int            lat;
    logic [63:0]   held;

    always #5 clk = ~clk;

    // Execution unit stand-in: wrap-around ADD/SUB/MUL on one lane
    always_comb begin
        alu_result = '0;
        case (alu_opcode[2:0])
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = DW'(alu_a * alu_b);
            default: alu_result = '0;
        endcase
    end

    exec_sequencer dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_err(out_err), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag);
        @(negedge clk);
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        @(negedge clk);
        in_valid  = 1'b0;
        in_a      = '1;
        in_b      = '1;
        in_tag    = '1;
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hs_in_ready", {63'd0, in_ready}, 64'd1);
        check("hs_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = '0; in_a = '0; in_b = '0; in_tag = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_alu_a", {48'd0, alu_a}, 64'd0);

        issue(5'b00000, 64'h1111_2222_3333_0005, 64'h4444_5555_6666_0003, 4'd7);
        check("add_busy", {63'd0, busy}, 64'd1);
        wait_valid(lat);
        check("add_lat", 64'(lat), 64'd2);
        check("add_data", out_data, 64'h0000_0000_0000_0008);
        check("add_tag", {60'd0, out_tag}, 64'd7);
        check("add_err", {63'd0, out_err}, 64'd0);
        handshake();

        issue(5'b10010, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd2, 16'd2, 16'd2, 16'd2}, 4'd3);
        for (int i = 0; i < 12; i++) begin
            check("vmul_alu_a", {48'd0, alu_a}, 64'(i / 3 + 1));
            if (i < 11) @(negedge clk);
        end
        wait_valid(lat);
        check("vmul_lat", 64'(lat + 11), 64'd13);
        check("vmul_data", out_data, {16'd8, 16'd6, 16'd4, 16'd2});
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_data", out_data, held);
            check("bp_tag", {60'd0, out_tag}, 64'd3);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        handshake();

        issue(5'b11000, 64'h5, 64'h3, 4'd9);
        wait_valid(lat);
        check("rsv_lat", 64'(lat), 64'd1);
        check("rsv_err", {63'd0, out_err}, 64'd1);
        check("rsv_data", out_data, 64'd0);
        check("rsv_alu_a", {48'd0, alu_a}, 64'd0);
        handshake();
        check("rsv_err_clr", {63'd0, out_err}, 64'd0);

        issue(5'b10001, {16'd40, 16'd30, 16'd20, 16'd10}, {16'd4, 16'd3, 16'd2, 16'd1}, 4'd5);
        repeat (2) @(negedge clk);
        check("vsub_lane2", {48'd0, alu_a}, 64'd30);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        repeat (3) @(negedge clk);
        check("flush_no_valid", {63'd0, out_valid}, 64'd0);

        issue(5'b00001, 64'h1, 64'h2, 4'd2);
        wait_valid(lat);
        check("sub_lat", 64'(lat), 64'd2);
        check("sub_data", out_data, 64'h0000_0000_0000_FFFF);
        handshake();

        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; in_opcode = 5'b00000;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_beats_valid", {63'd0, busy}, 64'd0);

        issue(5'b01000, 64'h10, 64'h20, 4'd6);
        wait_valid(lat);
        check("fix_data", out_data, 64'h30);
        out_ready = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0;
        check("rst_done_valid", {63'd0, out_valid}, 64'd0);
        check("rst_done_ready", {63'd0, in_ready}, 64'd1);
        check("rst_done_data", out_data, 64'd0);
        check("rst_done_tag", {60'd0, out_tag}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
